// File: rtl/if_id_skid_latch_if.sv
// ---------------------------------------------------------------------------
// if_id_skid_latch_if
// Fetch-to-decode bundle for the IF/ID skid latch.
//   master : fetch/hazard side. Drives ihit, imemload, pcp4_IF, enable_ID and
//            flush_ID. Observes the decode-side outputs and the perf counters.
//   slave  : the IF/ID latch. Consumes the fetch/hazard controls and drives
//            instr_ID, pcp4_ID, valid_ID, fetch_hold, stall_cycles and
//            skid_events.
// ---------------------------------------------------------------------------
interface if_id_skid_latch_if #(
    parameter int WORD_W = 32
);
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] pcp4_IF;
    logic              enable_ID;
    logic              flush_ID;
    logic [WORD_W-1:0] instr_ID;
    logic [WORD_W-1:0] pcp4_ID;
    logic              valid_ID;
    logic              fetch_hold;
    logic [31:0]       stall_cycles;
    logic [31:0]       skid_events;

    modport master (
        output ihit, imemload, pcp4_IF, enable_ID, flush_ID,
        input  instr_ID, pcp4_ID, valid_ID, fetch_hold, stall_cycles, skid_events
    );

    modport slave (
        input  ihit, imemload, pcp4_IF, enable_ID, flush_ID,
        output instr_ID, pcp4_ID, valid_ID, fetch_hold, stall_cycles, skid_events
    );
endinterface

// File: rtl/if_id_skid_latch.sv
// ---------------------------------------------------------------------------
// if_id_skid_latch
// IF/ID pipeline register with a one-entry skid buffer. The latch holds the
// instruction and PC+4 presented to decode steady while the hazard unit
// stalls ID. An icache hit that lands during a stall is parked in the skid
// entry, and fetch_hold then stops the PC/icache until the skid drains, so no
// fetch is lost or duplicated.
//
// Ports
//   CLK, RST      : core clock and synchronous active-high reset
//   bus (slave)   : ihit/imemload/pcp4_IF    - fetch result
//                   enable_ID/flush_ID       - hazard unit controls
//                   instr_ID/pcp4_ID/valid_ID - decode-side latch contents
//                   fetch_hold               - back-pressure to PC/icache
//                   stall_cycles/skid_events - perf counters
//
// Build option
//   IF_ID_PERF_EN : when defined, the perf counters are implemented. When it
//                   is undefined, both counter outputs are tied to zero.
//
// Per-cycle priority is RST > flush_ID > enable_ID > ihit.
// ---------------------------------------------------------------------------
module if_id_skid_latch #(
    parameter int                 WORD_W   = 32,
    parameter logic [WORD_W-1:0]  NOP_WORD = '0
) (
    input logic                   CLK,
    input logic                   RST,
    if_id_skid_latch_if.slave     bus
);

    // State encoding is {skid_valid, latch_valid}, so both flags fall
    // straight out of the state bits.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        FULL      = 2'b01,
        BUB_SKID  = 2'b10,
        FULL_SKID = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pcp4_q, pcp4_d;
    logic [WORD_W-1:0] skid_instr_q, skid_instr_d;
    logic [WORD_W-1:0] skid_pcp4_q, skid_pcp4_d;
    logic              skid_valid;
    logic              latch_valid;

    assign skid_valid  = state_q[1];
    assign latch_valid = state_q[0];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= EMPTY;
            instr_q      <= NOP_WORD;
            pcp4_q       <= '0;
            skid_instr_q <= '0;
            skid_pcp4_q  <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pcp4_q       <= pcp4_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp4_q  <= skid_pcp4_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and next latch/skid contents
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pcp4_d       = pcp4_q;
        skid_instr_d = skid_instr_q;
        skid_pcp4_d  = skid_pcp4_q;

        if (bus.flush_ID) begin
            // Wrong-path squash: the latch, the skid and any same-cycle hit
            // are all discarded, whatever the stall state.
            state_d      = EMPTY;
            instr_d      = NOP_WORD;
            pcp4_d       = '0;
            skid_instr_d = '0;
            skid_pcp4_d  = '0;
        end else if (bus.enable_ID) begin
            if (skid_valid) begin
                // Drain the skid first. fetch_hold was high this cycle, so
                // any ihit now is not ours to accept.
                state_d      = FULL;
                instr_d      = skid_instr_q;
                pcp4_d       = skid_pcp4_q;
                skid_instr_d = '0;
                skid_pcp4_d  = '0;
            end else if (bus.ihit) begin
                state_d = FULL;
                instr_d = bus.imemload;
                pcp4_d  = bus.pcp4_IF;
            end else begin
                state_d = EMPTY;
                instr_d = NOP_WORD;
                pcp4_d  = '0;
            end
        end else if (bus.ihit && !skid_valid) begin
            // ID is stalled. Park the hit in the skid and keep the latch,
            // whether it holds an instruction or a bubble.
            state_d      = latch_valid ? FULL_SKID : BUB_SKID;
            skid_instr_d = bus.imemload;
            skid_pcp4_d  = bus.pcp4_IF;
        end
    end

    assign bus.instr_ID   = instr_q;
    assign bus.pcp4_ID    = pcp4_q;
    assign bus.valid_ID   = latch_valid;
    assign bus.fetch_hold = skid_valid;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] skid_cnt_q;
    logic        stall_tick;
    logic        skid_capture;

    // A stall cycle is counted only when ID holds a real instruction.
    assign stall_tick   = !bus.enable_ID && latch_valid;
    // Mirrors the capture branch above. A flush suppresses it.
    assign skid_capture = !bus.flush_ID && !bus.enable_ID && bus.ihit && !skid_valid;

    // The counters wrap naturally, and only RST clears them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            skid_cnt_q  <= '0;
        end else begin
            if (stall_tick)   stall_cnt_q <= stall_cnt_q + 32'd1;
            if (skid_capture) skid_cnt_q  <= skid_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.skid_events  = skid_cnt_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.skid_events  = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_latch.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid_latch
// Directed table of single-cycle vectors, followed by a hand-written
// perf-counter sequence. Inputs are applied before a rising edge, and the
// registered outputs are compared 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_if_id_skid_latch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_skid_latch_if #(.WORD_W(32)) bus ();

    if_id_skid_latch #(.WORD_W(32), .NOP_WORD(32'h0000_0000)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        ihit;
        logic [31:0] imem;
        logic [31:0] pc;
        logic        en;
        logic        fl;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_hold;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic h, input logic [31:0] im, input logic [31:0] pc,
                       input logic en, input logic fl, input logic [31:0] ei, input logic [31:0] ep,
                       input logic ev, input logic eh);
        vec_t v;
        v.rst = r; v.ihit = h; v.imem = im; v.pc = pc; v.en = en; v.fl = fl;
        v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_hold = eh;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic [31:0] im, input logic [31:0] pc,
                        input logic en, input logic fl);
        rst           = r;
        bus.ihit      = h;
        bus.imemload  = im;
        bus.pcp4_IF   = pc;
        bus.enable_ID = en;
        bus.flush_ID  = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_stall, exp_skid;

    initial begin
        //   rst ihit imem          pc       en fl  e_instr       e_pc     ev eh
        add(1, 1, 32'hDEAD_BEEF, 32'h08, 1, 0, 32'h0,         32'h0,   0, 0); // reset
        add(1, 1, 32'hDEAD_BEEF, 32'h08, 1, 0, 32'h0,         32'h0,   0, 0); // reset, cycle 2
        add(0, 1, 32'h8C22_0004, 32'h04, 1, 0, 32'h8C22_0004, 32'h04,  1, 0); // load, next cycle
        add(0, 1, 32'h0043_2020, 32'h08, 0, 0, 32'h8C22_0004, 32'h04,  1, 1); // stall, skid capture
        add(0, 1, 32'h1111_1111, 32'h0C, 0, 0, 32'h8C22_0004, 32'h04,  1, 1); // ihit ignored under hold
        add(0, 0, 32'h0,         32'h0,  0, 0, 32'h8C22_0004, 32'h04,  1, 1); // stall, no ihit
        add(0, 1, 32'h2222_2222, 32'h10, 1, 0, 32'h0043_2020, 32'h08,  1, 0); // drain skid
        add(0, 0, 32'h0,         32'h0,  1, 0, 32'h0,         32'h0,   0, 0); // bubble
        add(0, 0, 32'h0,         32'h0,  1, 0, 32'h0,         32'h0,   0, 0); // bubble again
        add(0, 1, 32'hAAAA_0001, 32'h10, 0, 0, 32'h0,         32'h0,   0, 1); // EMPTY->BUB_SKID
        add(0, 0, 32'h0,         32'h0,  1, 0, 32'hAAAA_0001, 32'h10,  1, 0); // drain into latch
        add(0, 1, 32'hBBBB_0002, 32'h14, 1, 0, 32'hBBBB_0002, 32'h14,  1, 0); // back-to-back load
        add(0, 1, 32'hCCCC_0003, 32'h18, 0, 0, 32'hBBBB_0002, 32'h14,  1, 1); // FULL_SKID
        add(0, 1, 32'hDDDD_0004, 32'h1C, 0, 1, 32'h0,         32'h0,   0, 0); // flush wins over stall
        add(0, 0, 32'h0,         32'h0,  1, 0, 32'h0,         32'h0,   0, 0); // skid never surfaces
        add(0, 1, 32'hEEEE_0005, 32'h20, 1, 0, 32'hEEEE_0005, 32'h20,  1, 0); // load
        add(0, 1, 32'hFFFF_0006, 32'h24, 1, 1, 32'h0,         32'h0,   0, 0); // flush drops ihit
        add(0, 1, 32'h1234_5678, 32'h24, 1, 0, 32'h1234_5678, 32'h24,  1, 0); // load
        add(0, 1, 32'h9ABC_DEF0, 32'h28, 0, 0, 32'h1234_5678, 32'h24,  1, 1); // FULL_SKID
        add(1, 0, 32'h0,         32'h0,  0, 0, 32'h0,         32'h0,   0, 0); // reset mid-skid
        add(0, 0, 32'h0,         32'h0,  1, 0, 32'h0,         32'h0,   0, 0); // skid discarded

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].ihit, vq[i].imem, vq[i].pc, vq[i].en, vq[i].fl);
            chk($sformatf("v%0d instr_ID", i), bus.instr_ID, vq[i].e_instr);
            chk($sformatf("v%0d pcp4_ID", i), bus.pcp4_ID, vq[i].e_pc);
            chk($sformatf("v%0d valid_ID", i), {31'b0, bus.valid_ID}, {31'b0, vq[i].e_valid});
            chk($sformatf("v%0d fetch_hold", i), {31'b0, bus.fetch_hold}, {31'b0, vq[i].e_hold});
        end

        // The reset above cleared the counters. Run 5 stall cycles with a
        // valid instruction and 1 skid capture, then add stalls on a bubble,
        // which must not count.
        step(0, 1, 32'h1357_0001, 32'h40, 1, 0);
        chk("perf load valid", {31'b0, bus.valid_ID}, 32'd1);
        step(0, 1, 32'h2468_0002, 32'h44, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 32'h0, 32'h0, 0, 0);
        chk("perf hold during stall", {31'b0, bus.fetch_hold}, 32'd1);
        chk("perf instr held", bus.instr_ID, 32'h1357_0001);
        step(0, 0, 32'h0, 32'h0, 1, 0);
        chk("perf skid drained", bus.instr_ID, 32'h2468_0002);
        chk("perf skid pcp4", bus.pcp4_ID, 32'h44);
        step(0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 0);
`ifdef IF_ID_PERF_EN
        exp_stall = 32'd5;
        exp_skid  = 32'd1;
`else
        exp_stall = 32'd0;
        exp_skid  = 32'd0;
`endif
        chk("stall_cycles", bus.stall_cycles, exp_stall);
        chk("skid_events", bus.skid_events, exp_skid);
        step(0, 1, 32'h5555_0000, 32'h48, 1, 1);
        chk("stall_cycles after flush", bus.stall_cycles, exp_stall);
        chk("skid_events after flush", bus.skid_events, exp_skid);
        step(1, 0, 32'h0, 32'h0, 0, 0);
        chk("stall_cycles after reset", bus.stall_cycles, 32'd0);
        chk("skid_events after reset", bus.skid_events, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
